// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access sequencer: request opcodes,
// sequencer states and the full-word byte-enable constant.
package mem_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_LDR  = 2'b01,
        OP_STR  = 2'b10,
        OP_SWP  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_CAP  = 2'b10,
        ST_WR   = 2'b11
    } state_e;

    localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data RAM: byte enables, store-data replication
// and zero-extended byte extraction from read data.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        lane,
    input  logic              is_byte,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [3:0]        be,
    output logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    // NOTE: every output gets a default before the conditional so no latch is inferred.
    always_comb begin
        be      = BE_WORD;
        wr_data = wdata;
        rd_data = rdata;
        if (is_byte) begin
            be           = 4'b0001 << lane;
            wr_data      = {(DATA_W/8){wdata[7:0]}};
            rd_data      = '0;
            rd_data[7:0] = rdata[int'(lane)*8 +: 8];
        end
    end

endmodule

// File: rtl/mem_access_seq.sv
// Memory-stage access sequencer: runs LDR, STR and atomic SWP against a
// synchronous data RAM, stalling the pipeline while an access is in flight.
module mem_access_seq
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [1:0]        req_op,
    input  logic              req_byte,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              stall,
    output logic [ADDR_W-1:0] dm_addr,
    output logic              dm_rd,
    output logic              dm_wr,
    output logic [3:0]        dm_be,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data
);

    state_e            state;
    op_e               op_q;
    logic              byte_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] old_data;

    logic              accept;
    logic [1:0]        sel_lane;
    logic              sel_byte;
    logic [3:0]        be;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    assign accept = (state == ST_IDLE) && req_valid && (req_op != OP_NONE);

    // Lane logic serves the incoming request in IDLE and the latched one afterwards.
    assign sel_lane = (state == ST_IDLE) ? req_addr[1:0] : lane_q;
    assign sel_byte = (state == ST_IDLE) ? req_byte      : byte_q;

    mem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .lane    (sel_lane),
        .is_byte (sel_byte),
        .wdata   (req_wdata),
        .rdata   (dm_rdata),
        .be      (be),
        .wr_data (wr_data),
        .rd_data (rd_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            op_q     <= OP_NONE;
            byte_q   <= 1'b0;
            lane_q   <= 2'b00;
            old_data <= '0;
            stall    <= 1'b0;
            dm_addr  <= '0;
            dm_rd    <= 1'b0;
            dm_wr    <= 1'b0;
            dm_be    <= '0;
            dm_wdata <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= op_e'(req_op);
                        byte_q   <= req_byte;
                        lane_q   <= req_addr[1:0];
                        dm_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        dm_be    <= be;
                        dm_wdata <= wr_data;
                        stall    <= 1'b1;
                        if (req_op == OP_STR) begin
                            state <= ST_WR;
                            dm_wr <= 1'b1;
                        end else begin
                            state <= ST_RD;
                            dm_rd <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    dm_rd <= 1'b0;
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    old_data <= rd_data;
                    if (op_q == OP_SWP) begin
                        state <= ST_WR;
                        dm_wr <= 1'b1;
                    end else begin
                        state    <= ST_IDLE;
                        stall    <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_data  <= rd_data;
                    end
                end
                ST_WR: begin
                    dm_wr <= 1'b0;
                    state <= ST_IDLE;
                    stall <= 1'b0;
                    if (op_q == OP_SWP) begin
                        wb_valid <= 1'b1;
                        wb_data  <= old_data;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
